// File: rtl/ipsxe_floating_point_horner_pkg_v1_0.sv
// Shared definitions for the Horner polynomial evaluator: FSM encoding,
// step-counter sizing and parameter legality.
package ipsxe_floating_point_horner_pkg_v1_0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ADD  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Counter holds k in [0, N_TERMS-2]; keep at least one bit so N_TERMS<=2 still elaborates.
  function automatic int cnt_width(input int n_terms);
    return (n_terms <= 2) ? 1 : $clog2(n_terms);
  endfunction

  function automatic bit params_ok(input int n_terms, input int mult_reg);
    return (n_terms >= 1) && ((mult_reg == 0) || (mult_reg == 1));
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_horner_mac_v1_0_if.sv
// Request/result handshake bundle for the Horner evaluator; slave is the
// evaluator side, master is the requester side.
interface ipsxe_floating_point_horner_mac_v1_0_if #(
  parameter int COEF_WIDTH = 16,
  parameter int Z_WIDTH    = 8,
  parameter int N_TERMS    = 4
);
  logic                            i_valid;
  logic                            o_ready;
  logic [N_TERMS*COEF_WIDTH-1:0]   i_coef;
  logic [Z_WIDTH-1:0]              i_z;
  logic                            o_valid;
  logic                            i_ready;
  logic [COEF_WIDTH-1:0]           o_result;

  modport slave  (input  i_valid, i_coef, i_z, i_ready,
                  output o_ready, o_valid, o_result);
  modport master (output i_valid, i_coef, i_z, i_ready,
                  input  o_ready, o_valid, o_result);
endinterface

// File: rtl/ipsxe_floating_point_horner_step_v1_0.sv
// One Horner step: c_k + ((acc*z) >> Z_WIDTH), with optional product register.
// IPSXE_HORNER_SAT_EN selects saturation instead of modulo wrap.
module ipsxe_floating_point_horner_step_v1_0 #(
  parameter int COEF_WIDTH = 16,
  parameter int Z_WIDTH    = 8,
  parameter int MULT_REG   = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_mul_en,
  input  logic [COEF_WIDTH-1:0] i_acc,
  input  logic [COEF_WIDTH-1:0] i_coef,
  input  logic [Z_WIDTH-1:0]    i_z,
  output logic [COEF_WIDTH-1:0] o_sum
);

  logic [COEF_WIDTH+Z_WIDTH-1:0] w_prod;
  logic [COEF_WIDTH-1:0]         w_p;
  logic [COEF_WIDTH-1:0]         w_p_use;
  logic [COEF_WIDTH-1:0]         r_p;

  assign w_prod = {{Z_WIDTH{1'b0}}, i_acc} * {{COEF_WIDTH{1'b0}}, i_z};
  assign w_p    = COEF_WIDTH'(w_prod >> Z_WIDTH);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_p <= '0;
    end else if (i_mul_en) begin
      r_p <= w_p;
    end
  end

  // With MULT_REG=0 the register is dead logic and the product feeds the adder directly.
  assign w_p_use = (MULT_REG != 0) ? r_p : w_p;

`ifdef IPSXE_HORNER_SAT_EN
  logic [COEF_WIDTH:0] w_sum_full;
  assign w_sum_full = {1'b0, i_coef} + {1'b0, w_p_use};
  assign o_sum      = w_sum_full[COEF_WIDTH] ? {COEF_WIDTH{1'b1}} : w_sum_full[COEF_WIDTH-1:0];
`else
  assign o_sum = i_coef + w_p_use;
`endif

endmodule

// File: rtl/ipsxe_floating_point_horner_mac_v1_0.sv
// Iterative Horner evaluator c0 + z*(c1 + z*(...)) over one shared step datapath.
// Define IPSXE_HORNER_SAT_EN for per-step saturation (default: modulo wrap).
module ipsxe_floating_point_horner_mac_v1_0
  import ipsxe_floating_point_horner_pkg_v1_0::*;
#(
  parameter int COEF_WIDTH = 16,
  parameter int Z_WIDTH    = 8,
  parameter int N_TERMS    = 4,
  parameter int MULT_REG   = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  ipsxe_floating_point_horner_mac_v1_0_if.slave io_bus
);

  localparam int KW = cnt_width(N_TERMS);

  generate
    if (!params_ok(N_TERMS, MULT_REG)) begin : g_param_err
      $error("ipsxe_floating_point_horner_mac_v1_0: illegal N_TERMS/MULT_REG");
    end
  endgenerate

  state_t                r_state;
  state_t                w_state_nxt;
  logic [COEF_WIDTH-1:0] r_acc;
  logic [COEF_WIDTH-1:0] w_acc_nxt;
  logic [COEF_WIDTH-1:0] r_result;
  logic [KW-1:0]         r_k;
  logic [COEF_WIDTH-1:0] r_coef [N_TERMS];
  logic [Z_WIDTH-1:0]    r_z;
  logic                  w_ready;
  logic                  w_accept;
  logic [COEF_WIDTH-1:0] w_sum;

  assign w_ready  = (r_state == ST_IDLE) && i_rst_n;
  assign w_accept = w_ready && io_bus.i_valid;

  ipsxe_floating_point_horner_step_v1_0 #(
    .COEF_WIDTH (COEF_WIDTH),
    .Z_WIDTH    (Z_WIDTH),
    .MULT_REG   (MULT_REG)
  ) u_step (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_mul_en (r_state == ST_MUL),
    .i_acc    (r_acc),
    .i_coef   (r_coef[r_k]),
    .i_z      (r_z),
    .o_sum    (w_sum)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    unique case (r_state)
      ST_IDLE: if (w_accept) begin
        w_acc_nxt   = io_bus.i_coef[(N_TERMS-1)*COEF_WIDTH +: COEF_WIDTH];
        w_state_nxt = (N_TERMS == 1) ? ST_DONE : ((MULT_REG == 1) ? ST_MUL : ST_ADD);
      end
      ST_MUL:  w_state_nxt = ST_ADD;
      ST_ADD: begin
        w_acc_nxt   = w_sum;
        w_state_nxt = (r_k == '0) ? ST_DONE : ((MULT_REG == 1) ? ST_MUL : ST_ADD);
      end
      ST_DONE: if (io_bus.i_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_k      <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      if (w_accept) begin
        r_k <= KW'(N_TERMS - 2);
      end else if (r_state == ST_ADD && r_k != '0) begin
        r_k <= r_k - 1'b1;
      end
      // Result register holds its value after the handshake until the next result.
      if (w_state_nxt == ST_DONE && r_state != ST_DONE) begin
        r_result <= w_acc_nxt;
      end
    end
  end

  // NOTE: the operand latch has no reset; it is always written on accept
  // before any step reads it, so clearing it would only cost logic.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      for (int i = 0; i < N_TERMS; i++) begin
        r_coef[i] <= io_bus.i_coef[i*COEF_WIDTH +: COEF_WIDTH];
      end
      r_z <= io_bus.i_z;
    end
  end

  assign io_bus.o_ready  = w_ready;
  assign io_bus.o_valid  = (r_state == ST_DONE) && i_rst_n;
  assign io_bus.o_result = r_result;

endmodule

// File: tb/tb_ipsxe_floating_point_horner_mac_v1_0.sv
// Directed bench for the Horner evaluator: MULT_REG=0/1, N_TERMS=1,
// overflow wrap/saturate, backpressure and mid-operation reset.
module tb_ipsxe_floating_point_horner_mac_v1_0;

`ifdef IPSXE_HORNER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [63:0] C_BASE = {16'd400, 16'd300, 16'd200, 16'd100};
  localparam logic [63:0] C_ONES = {4{16'hFFFF}};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ipsxe_floating_point_horner_mac_v1_0_if #(.COEF_WIDTH(16), .Z_WIDTH(8), .N_TERMS(4)) bus0 ();
  ipsxe_floating_point_horner_mac_v1_0_if #(.COEF_WIDTH(16), .Z_WIDTH(8), .N_TERMS(4)) bus1 ();
  ipsxe_floating_point_horner_mac_v1_0_if #(.COEF_WIDTH(16), .Z_WIDTH(8), .N_TERMS(1)) bus2 ();

  ipsxe_floating_point_horner_mac_v1_0 #(.COEF_WIDTH(16), .Z_WIDTH(8), .N_TERMS(4), .MULT_REG(0))
    dut0 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus0));
  ipsxe_floating_point_horner_mac_v1_0 #(.COEF_WIDTH(16), .Z_WIDTH(8), .N_TERMS(4), .MULT_REG(1))
    dut1 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus1));
  ipsxe_floating_point_horner_mac_v1_0 #(.COEF_WIDTH(16), .Z_WIDTH(8), .N_TERMS(1), .MULT_REG(0))
    dut2 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus2));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-exact reference: truncating multiply, then wrap or saturate at each step.
  function automatic logic [15:0] model(input logic [63:0] c, input logic [7:0] z, input bit sat);
    logic [15:0] acc;
    logic [31:0] prod;
    logic [16:0] s;
    acc = c[48 +: 16];
    for (int k = 2; k >= 0; k--) begin
      prod = {16'd0, acc} * {24'd0, z};
      s    = {1'b0, c[k*16 +: 16]} + {1'b0, prod[23:8]};
      acc  = (sat && s[16]) ? 16'hFFFF : s[15:0];
    end
    return acc;
  endfunction

  // Accept one request on dut0 and return cycles until o_valid (-1 on timeout).
  task automatic run0(input logic [63:0] c, input logic [7:0] z, output int lat, output logic [15:0] res);
    logic rdy;
    rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.o_ready) begin rdy = 1'b1; break; end
    end
    check("dut0_ready_before_req", rdy, 1);
    bus0.i_valid = 1'b1;
    bus0.i_coef  = c;
    bus0.i_z     = z;
    @(posedge clk);
    #1;
    bus0.i_valid = 1'b0;
    bus0.i_coef  = {$urandom, $urandom};
    bus0.i_z     = 8'($urandom);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus0.o_valid) begin lat = n; break; end
    end
    res = bus0.o_result;
  endtask

  task automatic release0();
    bus0.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus0.i_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [15:0] res;
    bus0.i_valid = 0; bus0.i_coef = '0; bus0.i_z = '0; bus0.i_ready = 0;
    bus1.i_valid = 0; bus1.i_coef = '0; bus1.i_z = '0; bus1.i_ready = 0;
    bus2.i_valid = 0; bus2.i_coef = '0; bus2.i_z = '0; bus2.i_ready = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_o_ready", bus0.o_ready, 0);
    check("rst_o_valid", bus0.o_valid, 0);
    check("rst_o_result", bus0.o_result, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_o_ready", bus0.o_ready, 1);
    check("post_rst_o_valid", bus0.o_valid, 0);

    // Main case, then hold the result under backpressure with a competing request
    run0(C_BASE, 8'h80, lat, res);
    check("base_latency", lat, 4);
    check("base_result", res, 325);
    bus0.i_valid = 1'b1;
    bus0.i_coef  = C_ONES;
    for (int i = 0; i < 5; i++) begin
      check("bp_o_valid", bus0.o_valid, 1);
      check("bp_o_result", bus0.o_result, 325);
      check("bp_o_ready", bus0.o_ready, 0);
      @(negedge clk);
    end
    bus0.i_valid = 1'b0;
    release0();
    @(negedge clk);
    check("rel_o_valid", bus0.o_valid, 0);
    check("rel_o_ready", bus0.o_ready, 1);
    check("rel_o_result_held", bus0.o_result, 325);
    @(negedge clk);
    check("no_phantom_valid", bus0.o_valid, 0);

    // z = 0 gives c0
    run0(C_BASE, 8'h00, lat, res);
    check("z0_latency", lat, 4);
    check("z0_result", res, 100);
    release0();

    // Overflow on every step
    run0(C_ONES, 8'hFF, lat, res);
    check("ovf_result_model", res, model(C_ONES, 8'hFF, SAT));
    check("ovf_result_const", res, SAT ? 16'hFFFF : 16'd64767);
    release0();

    // MULT_REG = 1
    @(negedge clk);
    check("mr1_ready", bus1.o_ready, 1);
    bus1.i_valid = 1'b1; bus1.i_coef = C_BASE; bus1.i_z = 8'h80;
    @(posedge clk); #1 bus1.i_valid = 1'b0; bus1.i_coef = '0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus1.o_valid) begin lat = n; break; end
    end
    check("mr1_latency", lat, 7);
    check("mr1_result", bus1.o_result, 325);
    bus1.i_ready = 1'b1;
    @(posedge clk); #1 bus1.i_ready = 1'b0;
    @(negedge clk);
    check("mr1_rel_o_valid", bus1.o_valid, 0);

    // N_TERMS = 1
    check("n1_ready", bus2.o_ready, 1);
    bus2.i_valid = 1'b1; bus2.i_coef = 16'h1234; bus2.i_z = 8'hC3;
    @(posedge clk); #1 bus2.i_valid = 1'b0; bus2.i_coef = '0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus2.o_valid) begin lat = n; break; end
    end
    check("n1_latency", lat, 1);
    check("n1_result", bus2.o_result, 16'h1234);
    bus2.i_ready = 1'b1;
    @(posedge clk); #1 bus2.i_ready = 1'b0;

    // Reset two cycles after accept aborts the computation
    @(negedge clk);
    check("abort_ready", bus0.o_ready, 1);
    bus0.i_valid = 1'b1; bus0.i_coef = C_BASE; bus0.i_z = 8'h80;
    @(posedge clk); #1 bus0.i_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("abort_in_rst_o_ready", bus0.o_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_o_valid", bus0.o_valid, 0);
    check("abort_o_result", bus0.o_result, 0);
    check("abort_o_ready", bus0.o_ready, 1);
    repeat (5) @(negedge clk);
    check("abort_no_late_valid", bus0.o_valid, 0);
    run0(C_BASE, 8'h80, lat, res);
    check("after_abort_latency", lat, 4);
    check("after_abort_result", res, 325);
    release0();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
